// File: rtl/ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings and pipeline-stage record for the edge-detection bus master.
// Also holds the helper that checks whether a core request is aligned to its transfer size.
package ahb_lite_master_pkg;

  localparam int AHB_ADDR_W = 32;
  localparam int AHB_DATA_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000
  } hburst_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef struct packed {
    logic                  valid;
    logic [AHB_ADDR_W-1:0] addr;
    logic                  write;
    logic [1:0]            size;
    logic [AHB_DATA_W-1:0] wdata;
  } stage_t;

  // Size code 3 has no legal meaning; larger sizes must be naturally aligned.
  function automatic logic reqLegal(input logic [1:0] size, input logic [1:0] addrLsb);
    logic ok;
    ok = 1'b0;
    case ({1'b0, size})
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addrLsb[0];
      HSIZE_WORD: ok = (addrLsb == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_lite_master_if.sv
// Core-request and AHB-Lite bus signals of the single-beat master, bundled in one interface.
// The master modport is the initiator's view; the slave modport is everything around it.
interface ahb_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              req;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_done;
  logic              err;
  logic [ADDR_W-1:0] err_addr;
  logic              busy;

  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    input  req, req_write, req_addr, req_size, req_wdata,
    input  hrdata, hready, hresp,
    output req_ack, rd_valid, rd_data, wr_done, err, err_addr, busy,
    output haddr, htrans, hwrite, hsize, hburst, hwdata
  );

  modport slave (
    output req, req_write, req_addr, req_size, req_wdata,
    output hrdata, hready, hresp,
    input  req_ack, rd_valid, rd_data, wr_done, err, err_addr, busy,
    input  haddr, htrans, hwrite, hsize, hburst, hwdata
  );

endinterface

// File: rtl/ahb_lite_master.sv
// Single-beat AHB-Lite initiator: an address stage (A) overlapping a data stage (D),
// with wait-state stalls, two-cycle ERROR handling and one-cycle completion pulses.
module ahb_lite_master
  import ahb_lite_master_pkg::*;
#(
  parameter int ADDR_W = AHB_ADDR_W,
  parameter int DATA_W = AHB_DATA_W
) (
  input logic              clk,
  input logic              n_rst,
  ahb_lite_master_if.master bus
);

  stage_t            a_q, a_d;
  stage_t            d_q, d_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_done_q, wr_done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic errResp;
  logic reqAck;
  logic reqOk;
  logic dComplete;
  logic busErr;
  logic illegalReq;
  logic unusedDSize;

  // An ERROR response on the data phase blocks new requests and cancels the address phase.
  always_comb begin
    errResp    = d_q.valid & (bus.hresp == HRESP_ERROR);
    reqAck     = bus.req & bus.hready & ~errResp;
    reqOk      = reqLegal(bus.req_size, bus.req_addr[1:0]);
    dComplete  = d_q.valid & bus.hready & (bus.hresp == HRESP_OKAY);
    busErr     = errResp & bus.hready;
    illegalReq = reqAck & ~reqOk;
  end

  // Stages only advance when the slave signals hready; the second ERROR cycle empties both.
  always_comb begin
    a_d = a_q;
    d_d = d_q;
    if (bus.hready) begin
      if (errResp) begin
        a_d = '0;
        d_d = '0;
      end else begin
        d_d = a_q;
        a_d = '0;
        if (reqAck && reqOk) begin
          a_d.valid = 1'b1;
          a_d.addr  = bus.req_addr;
          a_d.write = bus.req_write;
          a_d.size  = bus.req_size;
          a_d.wdata = bus.req_wdata;
        end
      end
    end
  end

  // A bus error always owns err_addr; illegal requests cannot be acked during one anyway.
  always_comb begin
    rd_valid_d = dComplete & ~d_q.write;
    rd_data_d  = rd_data_q;
    if (rd_valid_d) begin
      rd_data_d = bus.hrdata;
    end
    wr_done_d  = dComplete & d_q.write;
    err_d      = busErr | illegalReq;
    err_addr_d = err_addr_q;
    if (busErr) begin
      err_addr_d = d_q.addr;
    end else if (illegalReq) begin
      err_addr_d = bus.req_addr;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_q        <= '0;
      d_q        <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_done_q  <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      a_q        <= a_d;
      d_q        <= d_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      wr_done_q  <= wr_done_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // The data stage never needs the transfer size; it rides along only because D copies A.
  assign unusedDSize = ^d_q.size;

  assign bus.req_ack  = reqAck;
  assign bus.htrans   = (a_q.valid & ~errResp) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.haddr    = a_q.addr;
  assign bus.hwrite   = a_q.write;
  assign bus.hsize    = {1'b0, a_q.size};
  assign bus.hburst   = HBURST_SINGLE;
  assign bus.hwdata   = d_q.wdata;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.wr_done  = wr_done_q;
  assign bus.err      = err_q;
  assign bus.err_addr = err_addr_q;
  assign bus.busy     = a_q.valid | d_q.valid;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: directed bus scenarios plus a randomized run,
// all compared against a queue-based model of outstanding transfers.
module tb_ahb_lite_master;
  import ahb_lite_master_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  always #5 clk = ~clk;

  ahb_lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ahb_lite_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] addr;
    bit          isWrite;
    logic [1:0]  xsize;
    logic [31:0] wdata;
  } xfer_t;

  // Transfers on the address bus and in their data phase, oldest first.
  xfer_t       addrQ[$];
  xfer_t       dataQ[$];
  bit          mRdValid, mWrDone, mErr, mAck;
  logic [31:0] mRdData, mErrAddr;

  int testsRun = 0;
  int testsFailed = 0;

  bit          sAck, sRdValid, sWrDone, sErr, sBusy;
  logic [1:0]  sTrans;
  logic [31:0] sHaddr, sHwdata, sRdData, sErrAddr;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit isLegal(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 1'b0;
    return (addr % (32'd1 << size)) == 32'd0;
  endfunction

  // One bus cycle: drive at the falling edge, check, then advance the model past the rising edge.
  task automatic applyStimulus(input bit req, input bit wr, input logic [31:0] addr,
                               input logic [1:0] size, input logic [31:0] wdata,
                               input bit rdy, input bit resp, input logic [31:0] rdata);
    bit    dataBusy, expNonseq, flushed, nRd, nWr, nErr;
    xfer_t t;
    @(negedge clk);
    bus.req       = req;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_wdata = wdata;
    bus.hready    = rdy;
    bus.hresp     = resp;
    bus.hrdata    = rdata;
    #1;
    dataBusy  = (dataQ.size() != 0);
    mAck      = req && rdy && !(dataBusy && resp);
    expNonseq = (addrQ.size() != 0) && !(dataBusy && resp);

    sAck = bus.req_ack; sTrans = bus.htrans; sHaddr = bus.haddr; sHwdata = bus.hwdata;
    sRdValid = bus.rd_valid; sRdData = bus.rd_data; sWrDone = bus.wr_done;
    sErr = bus.err; sErrAddr = bus.err_addr; sBusy = bus.busy;

    checkOutput("req_ack", bus.req_ack, mAck);
    checkOutput("htrans", bus.htrans, expNonseq ? 2'b10 : 2'b00);
    checkOutput("busy", bus.busy, (addrQ.size() != 0) || dataBusy);
    checkOutput("hburst", bus.hburst, 3'b000);
    if (expNonseq) begin
      checkOutput("haddr", bus.haddr, addrQ[0].addr);
      checkOutput("hwrite", bus.hwrite, addrQ[0].isWrite);
      checkOutput("hsize", bus.hsize, {1'b0, addrQ[0].xsize});
    end
    if (dataBusy && dataQ[0].isWrite) checkOutput("hwdata", bus.hwdata, dataQ[0].wdata);
    checkOutput("rd_valid", bus.rd_valid, mRdValid);
    if (mRdValid) checkOutput("rd_data", bus.rd_data, mRdData);
    checkOutput("wr_done", bus.wr_done, mWrDone);
    checkOutput("err", bus.err, mErr);
    if (mErr) checkOutput("err_addr", bus.err_addr, mErrAddr);

    nRd = 0; nWr = 0; nErr = 0; flushed = 0;
    if (rdy) begin
      if (dataBusy) begin
        if (resp) begin
          nErr = 1; mErrAddr = dataQ[0].addr; flushed = 1;
          addrQ.delete();
        end else if (dataQ[0].isWrite) begin
          nWr = 1;
        end else begin
          nRd = 1; mRdData = rdata;
        end
        dataQ.delete();
      end
      if (!flushed && addrQ.size() != 0) begin
        t = addrQ.pop_front();
        dataQ.push_back(t);
      end
      if (mAck) begin
        if (isLegal(addr, size)) begin
          t = '{addr: addr, isWrite: wr, xsize: size, wdata: wdata};
          addrQ.push_back(t);
        end else begin
          nErr = 1; mErrAddr = addr;
        end
      end
    end
    mRdValid = nRd; mWrDone = nWr; mErr = nErr;
  endtask

  // Asynchronous reset a few ns after the falling edge, so it lands mid-cycle.
  task automatic applyReset();
    #3;
    n_rst = 1'b0;
    bus.req = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_size = '0;
    bus.req_wdata = '0; bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
    #1;
    checkOutput("rst_htrans", bus.htrans, 2'b00);
    checkOutput("rst_haddr", bus.haddr, 32'h0);
    checkOutput("rst_hwrite", bus.hwrite, 1'b0);
    checkOutput("rst_hsize", bus.hsize, 3'b000);
    checkOutput("rst_hwdata", bus.hwdata, 32'h0);
    checkOutput("rst_rd_valid", bus.rd_valid, 1'b0);
    checkOutput("rst_rd_data", bus.rd_data, 32'h0);
    checkOutput("rst_wr_done", bus.wr_done, 1'b0);
    checkOutput("rst_err", bus.err, 1'b0);
    checkOutput("rst_err_addr", bus.err_addr, 32'h0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    addrQ.delete(); dataQ.delete();
    mRdValid = 0; mWrDone = 0; mErr = 0; mRdData = '0; mErrAddr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    int          wrCount, rdCount, errCount, nonseqCount;
    logic [31:0] rdSeen[$];
    bit          pReq, pWr;
    logic [31:0] pAddr, pWdata;
    logic [1:0]  pSize;
    int          errStage, r;
    bit          rdy, resp;

    applyReset();

    // Zero-wait write then read of the same word.
    applyStimulus(1, 1, 32'h4, 2'd2, 32'h1000_0000, 1, 0, 32'h0);
    checkOutput("s1_ack_write", sAck, 1'b1);
    applyStimulus(1, 0, 32'h4, 2'd2, 32'h0, 1, 0, 32'h0);
    checkOutput("s1_nonseq_write", sTrans, 2'b10);
    checkOutput("s1_haddr", sHaddr, 32'h4);
    applyStimulus(0, 0, 32'h0, 2'd0, 32'h0, 1, 0, 32'h0);
    checkOutput("s1_nonseq_read", sTrans, 2'b10);
    checkOutput("s1_hwdata", sHwdata, 32'h1000_0000);
    applyStimulus(0, 0, 32'h0, 2'd0, 32'h0, 1, 0, 32'hFFFF_FFFF);
    checkOutput("s1_wr_done", sWrDone, 1'b1);
    applyStimulus(0, 0, 32'h0, 2'd0, 32'h0, 1, 0, 32'h0);
    checkOutput("s1_rd_valid", sRdValid, 1'b1);
    checkOutput("s1_rd_data", sRdData, 32'hFFFF_FFFF);

    // Three wait states on a write data phase with a read queued in the address stage.
    applyStimulus(1, 1, 32'h8, 2'd2, 32'hA5A5_A5A5, 1, 0, 32'h0);
    applyStimulus(1, 0, 32'h8, 2'd2, 32'h0, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 32'h0, 2'd2, 32'h0, 0, 0, 32'h0);
      checkOutput("s2_htrans", sTrans, 2'b10);
      checkOutput("s2_haddr", sHaddr, 32'h8);
      checkOutput("s2_hwdata", sHwdata, 32'hA5A5_A5A5);
      checkOutput("s2_ack", sAck, 1'b0);
    end
    applyStimulus(1, 0, 32'h0, 2'd2, 32'h0, 1, 0, 32'h0);
    wrCount = sWrDone;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 32'h0, 2'd0, 32'h0, 1, 0, $urandom);
      wrCount += sWrDone;
    end
    checkOutput("s2_wr_done_count", wrCount, 1);

    // Two-cycle ERROR on a read while a write waits in the address stage.
    applyStimulus(1, 0, 32'hC, 2'd2, 32'h0, 1, 0, 32'h0);
    applyStimulus(1, 1, 32'h10, 2'd2, 32'h55, 1, 0, 32'h0);
    applyStimulus(1, 0, 32'h20, 2'd2, 32'h0, 0, 1, 32'h0);
    checkOutput("s3_htrans_err1", sTrans, 2'b00);
    checkOutput("s3_ack_err1", sAck, 1'b0);
    applyStimulus(1, 0, 32'h20, 2'd2, 32'h0, 1, 1, 32'h0);
    checkOutput("s3_ack_err2", sAck, 1'b0);
    applyStimulus(1, 0, 32'h20, 2'd2, 32'h0, 1, 0, 32'h0);
    checkOutput("s3_err", sErr, 1'b1);
    checkOutput("s3_err_addr", sErrAddr, 32'hC);
    checkOutput("s3_idle_after", sTrans, 2'b00);
    wrCount = 0; rdCount = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 32'h0, 2'd0, 32'h0, 1, 0, $urandom);
      wrCount += sWrDone; rdCount += sRdValid;
    end
    checkOutput("s3_no_wr_done", wrCount, 0);
    checkOutput("s3_rd_count", rdCount, 1);

    // Misaligned word request is acked but never reaches the bus.
    applyStimulus(1, 1, 32'h2, 2'd2, 32'h1234, 1, 0, 32'h0);
    checkOutput("s4_ack", sAck, 1'b1);
    applyStimulus(0, 0, 32'h0, 2'd0, 32'h0, 1, 0, 32'h0);
    checkOutput("s4_no_nonseq", sTrans, 2'b00);
    checkOutput("s4_err", sErr, 1'b1);
    checkOutput("s4_err_addr", sErrAddr, 32'h2);

    // Back-to-back reads at full throughput; slave data tracks the cycle number.
    nonseqCount = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(k < 4, 0, 32'(k * 4), 2'd2, 32'h0, 1, 0, 32'hD000_0000 + 32'(k));
      if (sTrans == 2'b10) nonseqCount++;
      if (sRdValid) rdSeen.push_back(sRdData);
    end
    checkOutput("s5_nonseq_count", nonseqCount, 4);
    checkOutput("s5_rd_count", rdSeen.size(), 4);
    for (int i = 0; i < 4 && i < rdSeen.size(); i++)
      checkOutput("s5_rd_data", rdSeen[i], 32'hD000_0002 + 32'(i));

    // Reset during a write data phase; nothing may complete afterwards.
    applyStimulus(1, 1, 32'h40, 2'd2, 32'hCAFE_0001, 1, 0, 32'h0);
    applyStimulus(1, 0, 32'h44, 2'd2, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 0, 32'h0, 2'd0, 32'h0, 0, 0, 32'h0);
    applyReset();
    wrCount = 0; rdCount = 0; errCount = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 32'h0, 2'd0, 32'h0, 1, 0, $urandom);
      wrCount += sWrDone; rdCount += sRdValid; errCount += sErr;
    end
    checkOutput("s6_no_pulses", wrCount + rdCount + errCount, 0);
    checkOutput("s6_busy", sBusy, 1'b0);

    // Randomized traffic: held requests, random wait states and occasional ERROR responses.
    pReq = 0; pWr = 0; pAddr = '0; pSize = '0; pWdata = '0; errStage = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!pReq && $urandom_range(0, 2) != 0) begin
        pReq = 1;
        pWr = $urandom_range(0, 1);
        r = $urandom_range(0, 15);
        pSize = (r == 0) ? 2'd3 : 2'(r % 3);
        pAddr = (32'($urandom_range(0, 1023)) << 2) |
                (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
        pWdata = $urandom;
      end
      if (errStage == 1) begin
        rdy = 1; resp = 1; errStage = 0;
      end else if (dataQ.size() != 0 && $urandom_range(0, 9) == 0) begin
        rdy = 0; resp = 1; errStage = 1;
      end else begin
        resp = 0;
        rdy = (dataQ.size() == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      applyStimulus(pReq, pWr, pAddr, pSize, pWdata, rdy, resp, $urandom);
      if (mAck) pReq = 0;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
